// File: rtl/wash_fsm.sv
// Washing-machine program sequencer: FWD -> PAUSE1 -> REV -> PAUSE2, repeated N_CYCLES times, then DONE.
// Moore outputs decoded from state; the synchronous reset wins over every transition.
module wash_fsm #(
    parameter int WIDTH      = 16,
    parameter int FWD_TIME   = 5,
    parameter int PAUSE_TIME = 2,
    parameter int REV_TIME   = 5,
    parameter int N_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] motor,
    output logic       compl_n
);

    localparam int CW = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;

    localparam logic [WIDTH-1:0] FWD_LAST   = WIDTH'(FWD_TIME - 1);
    localparam logic [WIDTH-1:0] PAUSE_LAST = WIDTH'(PAUSE_TIME - 1);
    localparam logic [WIDTH-1:0] REV_LAST   = WIDTH'(REV_TIME - 1);
    localparam logic [CW-1:0]    CYC_LAST   = CW'(N_CYCLES - 1);

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_FWD  = 2'b01;
    localparam logic [1:0] MOTOR_REV  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_PAUSE1,
        S_REV,
        S_PAUSE2,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] timer_q, timer_d;
    logic [CW-1:0]    cyc_q,   cyc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cyc_q   <= cyc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FWD;
                timer_d = '0;
                cyc_d   = '0;
            end
            S_FWD: begin
                if (timer_q == FWD_LAST) begin
                    state_d = S_PAUSE1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + WIDTH'(1);
                end
            end
            S_PAUSE1: begin
                if (timer_q == PAUSE_LAST) begin
                    state_d = S_REV;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + WIDTH'(1);
                end
            end
            S_REV: begin
                if (timer_q == REV_LAST) begin
                    state_d = S_PAUSE2;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + WIDTH'(1);
                end
            end
            S_PAUSE2: begin
                if (timer_q == PAUSE_LAST) begin
                    timer_d = '0;
                    // The cycle counter only advances when another wash cycle follows.
                    if (cyc_q == CYC_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cyc_d   = cyc_q + CW'(1);
                        state_d = S_FWD;
                    end
                end else begin
                    timer_d = timer_q + WIDTH'(1);
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                cyc_d   = '0;
            end
        endcase
    end

    always_comb begin
        motor   = MOTOR_STOP;
        compl_n = 1'b1;
        case (state_q)
            S_FWD:   motor   = MOTOR_FWD;
            S_REV:   motor   = MOTOR_REV;
            S_DONE:  compl_n = 1'b0;
            default: motor   = MOTOR_STOP;
        endcase
    end

endmodule

// File: tb/tb_wash_fsm.sv
// Bench for wash_fsm: directed segment tables plus a randomized reset-storm run
// against an arithmetic model of the program timeline.
module tb_wash_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_sw = 1'b1;
    logic [1:0] motor, motor_sw;
    logic       compl_n, compl_n_sw;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] prev_a = 2'b00;
    logic [1:0] prev_b = 2'b00;

    typedef struct {
        logic       rst;
        int         n;
        logic [1:0] motor;
        logic       compl_n;
    } seg_t;

    seg_t segs[$];

    always #5 clk = ~clk;

    wash_fsm u_dut (
        .clk     (clk),
        .rst     (rst),
        .motor   (motor),
        .compl_n (compl_n)
    );

    wash_fsm #(
        .WIDTH      (4),
        .FWD_TIME   (1),
        .PAUSE_TIME (1),
        .REV_TIME   (1),
        .N_CYCLES   (1)
    ) u_sw (
        .clk     (clk),
        .rst     (rst_sw),
        .motor   (motor_sw),
        .compl_n (compl_n_sw)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit unsafe(input logic [1:0] p, input logic [1:0] c);
        return (c == 2'b11) || (p == 2'b01 && c == 2'b10) || (p == 2'b10 && c == 2'b01);
    endfunction

    // One clock: inputs already driven; outputs sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        chk("dir_safety_main", int'(unsafe(prev_a, motor)), 0);
        chk("dir_safety_sweep", int'(unsafe(prev_b, motor_sw)), 0);
        prev_a = motor;
        prev_b = motor_sw;
    endtask

    function automatic void add(input logic r, input int n, input logic [1:0] m, input logic c);
        seg_t s;
        s.rst = r; s.n = n; s.motor = m; s.compl_n = c;
        segs.push_back(s);
    endfunction

    // Full default program (cycles 0..27) followed by the first DONE cycle.
    function automatic void add_prog();
        for (int i = 0; i < 2; i++) begin
            add(1'b0, 5, 2'b01, 1'b1);
            add(1'b0, 2, 2'b00, 1'b1);
            add(1'b0, 5, 2'b10, 1'b1);
            add(1'b0, 2, 2'b00, 1'b1);
        end
        add(1'b0, 1, 2'b00, 1'b0);
    endfunction

    // Reference: position in the program timeline; -1 means idle / in reset.
    function automatic int next_pos(input int pos, input logic r, input int total);
        if (r) return -1;
        if (pos < 0) return 0;
        if (pos < total) return pos + 1;
        return pos;
    endfunction

    function automatic logic [2:0] ref_out(input int pos, input int f, input int p,
                                           input int rv, input int n);
        int period, k;
        period = f + p + rv + p;
        if (pos < 0) return 3'b001;
        if (pos >= n * period) return 3'b000;
        k = pos % period;
        if (k < f) return 3'b011;
        if (k < f + p) return 3'b001;
        if (k < f + p + rv) return 3'b101;
        return 3'b001;
    endfunction

    initial begin
        logic [2:0] exp_a, exp_b;
        int pos_a, pos_b;
        logic [1:0] sw_motor [9];
        logic       sw_compl [9];

        // Power-up, full program, hold in DONE
        add(1'b1, 2, 2'b00, 1'b1);
        add_prog();
        add(1'b0, 50, 2'b00, 1'b0);
        // Reset in DONE, then a full rerun
        add(1'b1, 1, 2'b00, 1'b1);
        add_prog();
        // Mid-program reset during the second FWD
        add(1'b1, 1, 2'b00, 1'b1);
        add(1'b0, 5, 2'b01, 1'b1);
        add(1'b0, 2, 2'b00, 1'b1);
        add(1'b0, 5, 2'b10, 1'b1);
        add(1'b0, 2, 2'b00, 1'b1);
        add(1'b0, 1, 2'b01, 1'b1);
        add(1'b1, 16, 2'b00, 1'b1);
        add(1'b0, 5, 2'b01, 1'b1);
        add(1'b0, 2, 2'b00, 1'b1);

        foreach (segs[i]) begin
            for (int j = 0; j < segs[i].n; j++) begin
                rst = segs[i].rst;
                tick();
                chk($sformatf("seg%0d_motor", i), int'(motor), int'(segs[i].motor));
                chk($sformatf("seg%0d_compl_n", i), int'(compl_n), int'(segs[i].compl_n));
            end
        end

        // Minimal-parameter program: one-cycle phases, single wash cycle
        sw_motor = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        sw_compl = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
        for (int i = 0; i < 9; i++) begin
            rst_sw = (i == 0);
            tick();
            chk($sformatf("sweep%0d_motor", i), int'(motor_sw), int'(sw_motor[i]));
            chk($sformatf("sweep%0d_compl_n", i), int'(compl_n_sw), int'(sw_compl[i]));
        end

        // Randomized reset storms against the timeline model
        rst = 1'b1;
        rst_sw = 1'b1;
        tick();
        pos_a = -1;
        pos_b = -1;
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(0, 99) < 2);
            rst_sw = ($urandom_range(0, 99) < 10);
            tick();
            pos_a = next_pos(pos_a, rst, 28);
            pos_b = next_pos(pos_b, rst_sw, 4);
            exp_a = ref_out(pos_a, 5, 2, 5, 2);
            exp_b = ref_out(pos_b, 1, 1, 1, 1);
            chk("rand_main", int'({motor, compl_n}), int'(exp_a));
            chk("rand_sweep", int'({motor_sw, compl_n_sw}), int'(exp_b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
